serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial adder stage that feeds the team's 1-bit full adder cell. That cell is purely combinational, with ports s, c, a, b, p.
- Loads two WIDTH-bit operands and presents one bit pair per clock to a single fulladder instance, LSB first.
- The carry-out is registered and fed back as the next bit's carry-in.
- Sum bits are collected in a shift register, and a done pulse is raised when the word is complete.
- Sits between the operand source (lab register file / switches) and the result display logic.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin an addition; sampled only in IDLE or DONE.
- a_in  input  WIDTH  operand A; captured on the accepting edge.
- b_in  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  initial carry-in; captured on the accepting edge.
- busy  output  1  high while the addition is in progress (state RUN).
- done  output  1  one-cycle pulse; result is valid.
- sum  output  WIDTH  registered result; holds its value until the next completion.
- cout  output  1  registered final carry; holds its value until the next completion.

Behaviour:
- Reset: rst_n low clears asynchronously, regardless of clk:
  - state = IDLE;
  - busy, done, sum, cout = 0;
  - internal operand shift registers, carry flop and bit counter = 0.
- Reset mid-RUN abandons the operation. No done pulse is produced, and sum/cout read 0.
- Reset release is synchronous to the next clk edge (no action on the release itself).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0: load a_in, b_in into shift registers; carry flop <= cin; counter <= 0; go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1):
  - The fulladder inputs are a=A[0], b=B[0], p=carry flop.
  - Each edge: A, B shift right (MSB filled with 0); sum-shift register shifts right with the full adder s output entering the MSB; carry flop <= full adder c; counter <= counter+1.
  - The edge that processes bit WIDTH-1 (edge E_WIDTH) does three things: copies the completed sum word into sum; copies the carry into cout; goes to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - start=1 on that edge is accepted as a new E0 (back-to-back operation, go to RUN).
  - Otherwise go to IDLE.
- Latency: done is high in the cycle following edge E_WIDTH, i.e. WIDTH clocks after the accepting edge. Throughput is one addition per WIDTH+1 clocks.
- start while in RUN is ignored. Operands presented during RUN are not captured.
- a_in, b_in and cin changing after E0 have no effect on the result.
- Arithmetic: {cout,sum} = a_in + b_in + cin, modulo 2^(WIDTH+1); no overflow flag.
- Counter width: ceil(log2(WIDTH+1)) bits. The counter never wraps within an operation.
- sum/cout change only at completion or reset. They are stable through the following IDLE and RUN cycles.
- No combinational path from any input to any output.

Test Plan:
- Reset then WIDTH=8, a_in=0x5A, b_in=0x3C, cin=0, start one cycle:
  - busy=1 for 8 cycles;
  - done pulses the 8th clock after the accept edge;
  - sum=0x96, cout=0.
- a_in=0xFF, b_in=0x01, cin=0 -> sum=0x00, cout=1. Then a_in=0xFF, b_in=0x00, cin=1 -> sum=0x00, cout=1.
- start held high continuously with a_in=0x10, b_in=0x20:
  - new op accepted in each DONE cycle;
  - done every 9 clocks;
  - sum=0x30 each time;
  - start during RUN has no effect.
- Change a_in/b_in to 0xAA/0x55 mid-RUN of op 0x01+0x02 -> result sum=0x03, cout=0.
- Assert rst_n=0 asynchronously (between edges) 4 cycles into an op:
  - busy, done, sum, cout go to 0 immediately, without waiting for an edge;
  - after release, the next start of 0x7F+0x01 gives sum=0x80, cout=0.
- Exhaustive sweep with WIDTH=4: all a, b in 0..15, cin in {0,1} -> {cout,sum} equals a+b+cin for every case, and every done pulse is exactly one cycle wide.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: walks two WIDTH-bit operands LSB first through one full adder
// cell, recirculating the carry, and presents the registered word with a done pulse.

module fulladder (
    output logic s,
    output logic c,
    input  logic a,
    input  logic b,
    input  logic p
);

    // One-bit sum and carry of a + b + p.
    always_comb begin
        s = a ^ b ^ p;
        c = (a & b) | (p & (a ^ b));
    end

endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             fa_s;
    logic             fa_c;

    fulladder u_fa (
        .s (fa_s),
        .c (fa_c),
        .a (a_sh_q[0]),
        .b (b_sh_q[0]),
        .p (carry_q)
    );

    // Next-state and datapath decode; sum/cout only move on the final bit.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d  = a_in;
                    b_sh_d  = b_in;
                    s_sh_d  = {WIDTH{1'b0}};
                    carry_d = cin;
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                s_sh_d  = {fa_s, s_sh_q[WIDTH-1:1]};
                carry_d = fa_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = {fa_s, s_sh_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= {WIDTH{1'b0}};
            b_sh_q  <= {WIDTH{1'b0}};
            s_sh_q  <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit instance for directed and random
// operations, and a 4-bit instance for an exhaustive operand sweep.

module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    int tests = 0;
    int fails = 0;

    logic [8:0] q8[$];
    logic [4:0] q4[$];
    logic [8:0] last8, exp8;
    logic [4:0] last4, exp4;
    int         bcnt8, bcnt4;
    logic       pdone8, pdone4;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a_in(a4), .b_in(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        tests++;
        fails++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Monitor for the 8-bit instance: pops the scoreboard on each done pulse.
    initial begin
        last8 = '0; bcnt8 = 0; pdone8 = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last8 = '0; bcnt8 = 0; pdone8 = 1'b0;
            end else if (done8) begin
                if (q8.size() == 0) begin
                    fail_now("done8 with empty scoreboard");
                end else begin
                    exp8 = q8.pop_front();
                    check("sum8", {23'd0, cout8, sum8}, {23'd0, exp8});
                    last8 = exp8;
                end
                check("busy8 cycles before done", bcnt8, 8);
                check("done8 one cycle wide", {31'd0, pdone8}, 32'd0);
                check("busy8 low in done", {31'd0, busy8}, 32'd0);
                bcnt8 = 0;
                pdone8 = 1'b1;
            end else begin
                check("sum8 hold", {23'd0, cout8, sum8}, {23'd0, last8});
                if (busy8) bcnt8++;
                pdone8 = 1'b0;
            end
        end
    end

    // Monitor for the 4-bit instance.
    initial begin
        last4 = '0; bcnt4 = 0; pdone4 = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last4 = '0; bcnt4 = 0; pdone4 = 1'b0;
            end else if (done4) begin
                if (q4.size() == 0) begin
                    fail_now("done4 with empty scoreboard");
                end else begin
                    exp4 = q4.pop_front();
                    check("sum4", {27'd0, cout4, sum4}, {27'd0, exp4});
                    last4 = exp4;
                end
                check("busy4 cycles before done", bcnt4, 4);
                check("done4 one cycle wide", {31'd0, pdone4}, 32'd0);
                bcnt4 = 0;
                pdone4 = 1'b1;
            end else begin
                check("sum4 hold", {27'd0, cout4, sum4}, {27'd0, last4});
                if (busy4) bcnt4++;
                pdone4 = 1'b0;
            end
        end
    end

    // Issue one 8-bit op from a negedge; disturbs inputs during RUN; returns on the done negedge.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit fixed_scr);
        int n;
        bit got;
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        q8.push_back(9'(a) + 9'(b) + 9'(c));
        @(posedge clk);
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (done8) begin
                got = 1'b1;
            end else begin
                start8 = 1'($urandom_range(0, 1));
                a8 = fixed_scr ? 8'hAA : 8'($urandom);
                b8 = fixed_scr ? 8'h55 : 8'($urandom);
                cin8 = 1'($urandom_range(0, 1));
            end
        end
        start8 = 1'b0;
        if (!got) fail_now("op8 timeout waiting for done");
        else check("op8 latency in negedges", n, 9);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c);
        int n;
        bit got;
        a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
        q4.push_back(5'(a) + 5'(b) + 5'(c));
        @(posedge clk);
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (done4) begin
                got = 1'b1;
            end else begin
                start4 = 1'($urandom_range(0, 1));
                a4 = 4'($urandom);
                b4 = 4'($urandom);
                cin4 = 1'($urandom_range(0, 1));
            end
        end
        start4 = 1'b0;
        if (!got) fail_now("op4 timeout waiting for done");
        else check("op4 latency in negedges", n, 5);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit got;
        rst_n = 1'b1;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check("reset busy", {31'd0, busy8}, 32'd0);
        check("reset done", {31'd0, done8}, 32'd0);
        check("reset sum", {24'd0, sum8}, 32'd0);
        check("reset cout", {31'd0, cout8}, 32'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);

        op8(8'h5A, 8'h3C, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        op8(8'hFF, 8'h01, 1'b0, 1'b0);
        op8(8'hFF, 8'h00, 1'b1, 1'b0);

        // Start held high: each DONE cycle accepts the next op.
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(9'h030);
        for (int i = 0; i < 4; i++) begin
            n = 0; got = 1'b0;
            while (!got && n < 40) begin
                @(negedge clk);
                n++;
                got = done8;
            end
            if (!got) fail_now("held-start timeout");
            else check("held-start done period", n, 9);
            if (i < 3) q8.push_back(9'h030);
            else start8 = 1'b0;
        end

        op8(8'h01, 8'h02, 1'b0, 1'b1);

        // Asynchronous reset four cycles into an op.
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h44; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset busy", {31'd0, busy8}, 32'd0);
        check("async reset done", {31'd0, done8}, 32'd0);
        check("async reset sum", {24'd0, sum8}, 32'd0);
        check("async reset cout", {31'd0, cout8}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        op8(8'h7F, 8'h01, 1'b0, 1'b0);

        repeat (40) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    op4(4'(a), 4'(b), 1'(c));

        repeat (12) @(negedge clk);
        check("scoreboard8 drained", q8.size(), 0);
        check("scoreboard4 drained", q4.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
